// File: rtl/mmcm_lock_sequencer.sv
// MMCM bring-up sequencer: holds MMCM reset, waits for lock with timeout and
// bounded retries, requires stable lock before releasing the system reset,
// and restarts bring-up on lock loss or on request.
// Ports:
//   CLKIN1        in   free-running reference clock
//   ASYNC_RESET   in   asynchronous active-high reset
//   MMCM_LOCKED   in   LOCKED from the MMCM (asynchronous)
//   RESTART_REQ   in   one-cycle pulse forcing a fresh bring-up
//   MMCM_RST      out  MMCM reset
//   SYS_RESET     out  downstream reset, low only while running
//   READY         out  high only in RUNNING
//   FAIL          out  high only in FAILED
//   STATE         out  current state code
//   RETRY_CNT     out  timeouts in the current bring-up sequence
//   LOCK_LOSS_CNT out  saturating count of lock losses while running
module mmcm_lock_sequencer #(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65535,
    parameter int LOCK_STABLE_CYCLES  = 64,
    parameter int MAX_RETRIES         = 3,
    parameter int LOCKED_SYNC_STAGES  = 2
) (
    input  logic       CLKIN1,
    input  logic       ASYNC_RESET,
    input  logic       MMCM_LOCKED,
    input  logic       RESTART_REQ,
    output logic       MMCM_RST,
    output logic       SYS_RESET,
    output logic       READY,
    output logic       FAIL,
    output logic [2:0] STATE,
    output logic [3:0] RETRY_CNT,
    output logic [7:0] LOCK_LOSS_CNT
);

    localparam int MAX_AB = (RST_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                            RST_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_C  = (MAX_AB > LOCK_STABLE_CYCLES) ?
                            MAX_AB : LOCK_STABLE_CYCLES;
    localparam int TW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;
    localparam int SN     = LOCKED_SYNC_STAGES;

    localparam logic [TW-1:0] HOLD_LAST = TW'(RST_HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] STAB_LAST = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_HOLD = 3'd0,
        S_WAIT_LOCK  = 3'd1,
        S_STABILIZE  = 3'd2,
        S_RUNNING    = 3'd3,
        S_FAILED     = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [3:0]      retry_q, retry_d;
    logic [7:0]      llc_q, llc_d;
    logic [SN-1:0]   sync_q, sync_d;
    logic            mmcm_rst_q, mmcm_rst_d;
    logic            sys_reset_q, sys_reset_d;
    logic            ready_q, ready_d;
    logic            fail_q, fail_d;
    logic            lk;

    assign lk = sync_q[SN-1];

    always_comb begin
        sync_d      = {sync_q[SN-2:0], MMCM_LOCKED};
        state_d     = state_q;
        tmr_d       = tmr_q + TW'(1);
        retry_d     = retry_q;
        llc_d       = llc_q;

        if (RESTART_REQ) begin
            state_d = S_RESET_HOLD;
            tmr_d   = '0;
            retry_d = 4'd0;
        end else begin
            unique case (state_q)
                S_RESET_HOLD: begin
                    if (tmr_q == HOLD_LAST) begin
                        state_d = S_WAIT_LOCK;
                        tmr_d   = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    // A lock arriving on the timeout cycle still wins.
                    if (lk) begin
                        state_d = S_STABILIZE;
                        tmr_d   = '0;
                    end else if (tmr_q == TO_LAST) begin
                        tmr_d = '0;
                        if (retry_q == RETRY_MAX) begin
                            state_d = S_FAILED;
                        end else begin
                            state_d = S_RESET_HOLD;
                            retry_d = retry_q + 4'd1;
                        end
                    end
                end
                S_STABILIZE: begin
                    if (!lk) begin
                        state_d = S_WAIT_LOCK;
                        tmr_d   = '0;
                    end else if (tmr_q == STAB_LAST) begin
                        state_d = S_RUNNING;
                        tmr_d   = '0;
                    end
                end
                S_RUNNING: begin
                    // Timer parked so it cannot wrap while running.
                    tmr_d = '0;
                    if (!lk) begin
                        state_d = S_RESET_HOLD;
                        retry_d = 4'd0;
                        if (llc_q != 8'hFF) begin
                            llc_d = llc_q + 8'd1;
                        end
                    end
                end
                S_FAILED: begin
                    tmr_d = '0;
                end
                default: begin
                    state_d = S_RESET_HOLD;
                    tmr_d   = '0;
                end
            endcase
        end

        // Outputs decoded from the next state so they move with STATE.
        mmcm_rst_d  = (state_d == S_RESET_HOLD) || (state_d == S_FAILED);
        sys_reset_d = (state_d != S_RUNNING);
        ready_d     = (state_d == S_RUNNING);
        fail_d      = (state_d == S_FAILED);
    end

    always_ff @(posedge CLKIN1 or posedge ASYNC_RESET) begin
        if (ASYNC_RESET) begin
            state_q     <= S_RESET_HOLD;
            tmr_q       <= '0;
            retry_q     <= 4'd0;
            llc_q       <= 8'd0;
            sync_q      <= '0;
            mmcm_rst_q  <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            retry_q     <= retry_d;
            llc_q       <= llc_d;
            sync_q      <= sync_d;
            mmcm_rst_q  <= mmcm_rst_d;
            sys_reset_q <= sys_reset_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
        end
    end

    assign MMCM_RST      = mmcm_rst_q;
    assign SYS_RESET     = sys_reset_q;
    assign READY         = ready_q;
    assign FAIL          = fail_q;
    assign STATE         = state_q;
    assign RETRY_CNT     = retry_q;
    assign LOCK_LOSS_CNT = llc_q;

endmodule

// File: tb/tb_mmcm_lock_sequencer.sv
// Bench for mmcm_lock_sequencer: directed bring-up scenarios checked against
// a timestamp-based model every cycle plus hand-computed literals.
module tb_mmcm_lock_sequencer;

    localparam int HOLD    = 4;
    localparam int TO      = 20;
    localparam int STAB    = 8;
    localparam int RETRIES = 2;
    localparam int SYNC    = 2;

    logic       CLKIN1;
    logic       ASYNC_RESET;
    logic       MMCM_LOCKED;
    logic       RESTART_REQ;
    logic       MMCM_RST;
    logic       SYS_RESET;
    logic       READY;
    logic       FAIL;
    logic [2:0] STATE;
    logic [3:0] RETRY_CNT;
    logic [7:0] LOCK_LOSS_CNT;

    int n_total = 0;
    int n_bad   = 0;

    mmcm_lock_sequencer #(
        .RST_HOLD_CYCLES    (HOLD),
        .LOCK_TIMEOUT_CYCLES(TO),
        .LOCK_STABLE_CYCLES (STAB),
        .MAX_RETRIES        (RETRIES),
        .LOCKED_SYNC_STAGES (SYNC)
    ) dut (
        .CLKIN1       (CLKIN1),
        .ASYNC_RESET  (ASYNC_RESET),
        .MMCM_LOCKED  (MMCM_LOCKED),
        .RESTART_REQ  (RESTART_REQ),
        .MMCM_RST     (MMCM_RST),
        .SYS_RESET    (SYS_RESET),
        .READY        (READY),
        .FAIL         (FAIL),
        .STATE        (STATE),
        .RETRY_CNT    (RETRY_CNT),
        .LOCK_LOSS_CNT(LOCK_LOSS_CNT)
    );

    initial begin
        CLKIN1 = 1'b0;
        forever #5 CLKIN1 = ~CLKIN1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: state plus the cycle it was entered; elapsed time replaces a timer.
    int m_state = 0;
    int m_enter = 0;
    int m_cyc   = 0;
    int m_retry = 0;
    int m_llc   = 0;
    int m_s0    = 0;
    int m_s1    = 0;

    initial begin
        int lk, t, nxt, moved;
        forever begin
            @(posedge CLKIN1 or posedge ASYNC_RESET);
            if (ASYNC_RESET) begin
                m_state = 0; m_enter = 0; m_cyc = 0;
                m_retry = 0; m_llc = 0; m_s0 = 0; m_s1 = 0;
            end else begin
                lk    = m_s1;
                m_s1  = m_s0;
                m_s0  = int'(MMCM_LOCKED);
                t     = m_cyc - m_enter;
                nxt   = m_state;
                moved = 0;
                if (RESTART_REQ) begin
                    nxt = 0; m_retry = 0; moved = 1;
                end else if (m_state == 0) begin
                    if (t >= HOLD - 1) begin nxt = 1; moved = 1; end
                end else if (m_state == 1) begin
                    if (lk == 1) begin
                        nxt = 2; moved = 1;
                    end else if (t >= TO - 1) begin
                        moved = 1;
                        if (m_retry >= RETRIES) nxt = 4;
                        else begin nxt = 0; m_retry++; end
                    end
                end else if (m_state == 2) begin
                    if (lk == 0) begin nxt = 1; moved = 1; end
                    else if (t >= STAB - 1) begin nxt = 3; moved = 1; end
                end else if (m_state == 3) begin
                    if (lk == 0) begin
                        nxt = 0; moved = 1; m_retry = 0;
                        if (m_llc < 255) m_llc++;
                    end
                end
                if (moved == 1) m_enter = m_cyc + 1;
                m_state = nxt;
                m_cyc++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLKIN1);
            chk("state", int'(STATE), m_state);
            chk("mmcm_rst", int'(MMCM_RST), int'(m_state == 0 || m_state == 4));
            chk("sys_reset", int'(SYS_RESET), int'(m_state != 3));
            chk("ready", int'(READY), int'(m_state == 3));
            chk("fail", int'(FAIL), int'(m_state == 4));
            chk("retry_cnt", int'(RETRY_CNT), m_retry);
            chk("lock_loss_cnt", int'(LOCK_LOSS_CNT), m_llc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge CLKIN1);
        ASYNC_RESET = 1'b1;
        RESTART_REQ = 1'b0;
        repeat (2) @(negedge CLKIN1);
        chk("rst_state", int'(STATE), 0);
        chk("rst_mmcm_rst", int'(MMCM_RST), 1);
        chk("rst_sys_reset", int'(SYS_RESET), 1);
        chk("rst_ready", int'(READY), 0);
        chk("rst_fail", int'(FAIL), 0);
        ASYNC_RESET = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int budget);
        for (int i = 0; i < budget && !READY; i++) @(negedge CLKIN1);
        chk(name, int'(READY), 1);
    endtask

    initial begin
        int cnt;
        int seen;
        ASYNC_RESET = 1'b1;
        MMCM_LOCKED = 1'b0;
        RESTART_REQ = 1'b0;
        repeat (3) @(negedge CLKIN1);

        // 1: normal bring-up
        do_reset();
        cnt = 0;
        while (MMCM_RST && cnt < 100) begin cnt++; @(negedge CLKIN1); end
        chk("t1_hold_cycles", cnt, HOLD);
        repeat (10) @(negedge CLKIN1);
        MMCM_LOCKED = 1'b1;
        cnt = 0;
        do begin @(negedge CLKIN1); cnt++; end while (SYS_RESET && cnt < 100);
        chk("t1_lock_to_release", cnt, SYNC + STAB + 1);
        chk("t1_ready", int'(READY), 1);

        // 2: never locks -> FAILED, then restart
        MMCM_LOCKED = 1'b0;
        do_reset();
        cnt = 0; seen = 0;
        do begin
            @(negedge CLKIN1); cnt++;
            if (STATE == 3'd1) seen = seen | (1 << RETRY_CNT);
        end while (!FAIL && cnt < 300);
        chk("t2_cycles_to_fail", cnt, 3 * (HOLD + TO));
        chk("t2_retry_windows", seen, 7);
        chk("t2_retry_at_fail", int'(RETRY_CNT), 2);
        chk("t2_state_failed", int'(STATE), 4);
        chk("t2_mmcm_rst", int'(MMCM_RST), 1);
        repeat (30) @(negedge CLKIN1);
        chk("t2_still_failed", int'(FAIL), 1);
        RESTART_REQ = 1'b1;
        @(negedge CLKIN1);
        RESTART_REQ = 1'b0;
        chk("t2_restart_state", int'(STATE), 0);
        chk("t2_restart_retry", int'(RETRY_CNT), 0);

        // 3: lock glitch during STABILIZE
        MMCM_LOCKED = 1'b1;
        for (int i = 0; i < 40 && STATE != 3'd2; i++) @(negedge CLKIN1);
        chk("t3_reach_stab", int'(STATE), 2);
        repeat (4) @(negedge CLKIN1);
        MMCM_LOCKED = 1'b0;
        @(negedge CLKIN1);
        MMCM_LOCKED = 1'b1;
        for (int i = 0; i < 10 && STATE != 3'd1; i++) @(negedge CLKIN1);
        chk("t3_back_wait", int'(STATE), 1);
        chk("t3_retry_kept", int'(RETRY_CNT), 0);
        cnt = 0;
        do begin @(negedge CLKIN1); cnt++; end while (!READY && cnt < 50);
        chk("t3_relock_cycles", cnt, STAB + 1);

        // 4: lock loss while running, saturating counter
        MMCM_LOCKED = 1'b0;
        cnt = 0;
        do begin @(negedge CLKIN1); cnt++; end while (!SYS_RESET && cnt < 20);
        chk("t4_loss_latency", cnt, 3);
        chk("t4_state", int'(STATE), 0);
        chk("t4_loss_cnt", int'(LOCK_LOSS_CNT), 1);
        MMCM_LOCKED = 1'b1;
        for (int k = 0; k < 299; k++) begin
            wait_ready("t4_ready", 60);
            MMCM_LOCKED = 1'b0;
            @(negedge CLKIN1);
            MMCM_LOCKED = 1'b1;
            for (int i = 0; i < 10 && READY; i++) @(negedge CLKIN1);
        end
        chk("t4_loss_sat", int'(LOCK_LOSS_CNT), 255);

        // 5: restart on the final timeout cycle beats FAILED
        MMCM_LOCKED = 1'b0;
        do_reset();
        repeat (3 * (HOLD + TO) - 1) @(negedge CLKIN1);
        chk("t5_pre_state", int'(STATE), 1);
        chk("t5_pre_retry", int'(RETRY_CNT), 2);
        RESTART_REQ = 1'b1;
        @(negedge CLKIN1);
        RESTART_REQ = 1'b0;
        chk("t5_state", int'(STATE), 0);
        chk("t5_retry", int'(RETRY_CNT), 0);
        chk("t5_fail", int'(FAIL), 0);

        // 6: asynchronous reset while running
        MMCM_LOCKED = 1'b1;
        wait_ready("t6_ready", 80);
        @(posedge CLKIN1);
        #2;
        ASYNC_RESET = 1'b1;
        #1;
        chk("t6_sys_reset", int'(SYS_RESET), 1);
        chk("t6_mmcm_rst", int'(MMCM_RST), 1);
        chk("t6_state", int'(STATE), 0);
        chk("t6_ready", int'(READY), 0);
        chk("t6_loss_cnt", int'(LOCK_LOSS_CNT), 0);
        repeat (3) @(negedge CLKIN1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
